// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, handshaked memory between the instruction-fetch
// (IF) port and the data (MEM-stage) port. Accesses are serialised through
// IDLE -> BUSY_IF/BUSY_DM -> RESP, read data is returned per port with a
// one-cycle ready pulse, and per-port stall outputs let the hazard logic
// freeze the pipe while an access is outstanding. A watchdog aborts an
// access that the memory never acknowledges and raises a sticky bus_err.
//
// Optional feature macro:
//   ARB_RR_EN  - defined: simultaneous requests are granted round-robin
//                against last_grant. Undefined: DM always wins.
//
// Parameters:
//   ADDR_W   address width (both ports and memory side)
//   DATA_W   data width
//   TIMEOUT  max BUSY cycles without mem_ack before abort (2..255)
//
// Ports:
//   clock, reset         clock, asynchronous active-low reset
//   if_req/if_addr       fetch request (held until if_ready) and address
//   if_rdata/if_ready    fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, write flag, address, data
//   dm_rdata/dm_ready    load data and completion pulse
//   stall_if/stall_dm    combinational req & ~ready
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request fields
//   mem_rdata/mem_ack    memory read data and completion
//   bus_err              sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

`ifdef ARB_RR_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    grant_t     last_grant;
    logic [7:0] watchdog;
    logic       grant_dm;

    // Stalls only see the raw requests and the registered ready pulses.
    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;

    // Pick the winner for an IDLE grant. On contention, round-robin favours
    // the port not served last; fixed priority favours DM (older instruction).
    always_comb begin
        grant_dm = dm_req;
        if (if_req && dm_req) begin
            grant_dm = ROUND_ROBIN ? (last_grant == GRANT_IF) : 1'b1;
        end
    end

    // Single sequential FSM. Ready pulses default low every cycle and are
    // raised only on the edge that enters RESP, giving exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            watchdog   <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        mem_req  <= 1'b1;
                        watchdog <= 8'd0;
                        if (grant_dm) begin
                            mem_addr   <= dm_addr;
                            mem_we     <= dm_we;
                            mem_wdata  <= dm_wdata;
                            last_grant <= GRANT_DM;
                            state      <= BUSY_DM;
                        end else begin
                            // Fetches are reads; store data is left as is.
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            last_grant <= GRANT_IF;
                            state      <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (state == BUSY_IF) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ready <= 1'b1;
                        end
                    end else if (watchdog == WD_LIMIT) begin
                        // Abort: the port still completes, with all-ones data.
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= RESP;
                        if (state == BUSY_IF) begin
                            if_rdata <= '1;
                            if_ready <= 1'b1;
                        end else begin
                            dm_rdata <= '1;
                            dm_ready <= 1'b1;
                        end
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                RESP: begin
                    // Requests are ignored here so a held request is not reissued.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
